// File: rtl/pool2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pool2_ctrl
// Description : Sequencer for the second 2x2 max-pooling layer. Walks every
//               2x2 window of the f4 feature map (one 256-bit word per pixel,
//               16 maps in parallel) in raster order, issues one f4 read per
//               cycle, marks the first sample of each window with pool2_clr,
//               and issues the f5 write strobe/address once the execute
//               datapath has folded the fourth sample of a window.
// Options     : POOL2_PERF_EN - adds the pool2_cycles busy-cycle counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module pool2_ctrl #(
    parameter int IN_W   = 10,
    parameter int IN_H   = 10,
    parameter int F4_AW  = 7,
    parameter int F5_AW  = 5,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pool2_start,
    output logic             pool2_busy,
    output logic             pool2_done,
    output logic             f4_re,
    output logic [F4_AW-1:0] f4_raddr,
    output logic             pool2_clr,
    output logic             f5_we,
    output logic [F5_AW-1:0] f5_waddr
`ifdef POOL2_PERF_EN
    ,
    output logic [15:0]      pool2_cycles
`endif
);

    // ------------------------------------------------------------------------
    // Geometry of the pooled output
    // ------------------------------------------------------------------------
    localparam int WIN_W = IN_W / 2;
    localparam int WIN_H = IN_H / 2;
    localparam int NWIN  = WIN_W * WIN_H;
    localparam int WC_W  = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int WR_W  = (WIN_H > 1) ? $clog2(WIN_H) : 1;

    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WIN_W - 1);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(WIN_H - 1);
    localparam logic [F5_AW-1:0] WIN_LAST = F5_AW'(NWIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               f4_re_q,    f4_re_d;
    logic [F4_AW-1:0]   f4_raddr_q, f4_raddr_d;

    // Position of the read currently on the f4 port
    logic [1:0]         sub_q,      sub_d;
    logic [WC_W-1:0]    wcol_q,     wcol_d;
    logic [WR_W-1:0]    wrow_q,     wrow_d;
    logic [F5_AW-1:0]   win_q,      win_d;

    // Tag delay line: stage RD_LAT-1 lines up with the returning read data,
    // the final f5 stage sits one cycle later, after the datapath folds it.
    logic [RD_LAT-1:0]             clr_pipe_q,   clr_pipe_d;
    logic [RD_LAT-1:0]             we_pipe_q,    we_pipe_d;
    logic [RD_LAT-1:0][F5_AW-1:0]  waddr_pipe_q, waddr_pipe_d;
    logic                          f5_we_q,      f5_we_d;
    logic [F5_AW-1:0]              f5_waddr_q,   f5_waddr_d;

`ifdef POOL2_PERF_EN
    logic [15:0]        cycles_q,   cycles_d;
`endif

    logic               last_read;
    logic               win_end;

    // f4 pixel address of sample s of window (wr, wc)
    function automatic logic [F4_AW-1:0] pix_addr(
        input logic [WR_W-1:0] wr,
        input logic [WC_W-1:0] wc,
        input logic [1:0]      s
    );
        int row;
        int col;
        row = 2 * int'(wr) + int'(s[1]);
        col = 2 * int'(wc) + int'(s[0]);
        return F4_AW'(row * IN_W + col);
    endfunction

    // Window traversal detection for the read currently being issued
    always_comb begin
        win_end   = (sub_q == 2'd3);
        last_read = win_end && (wcol_q == WC_LAST) && (wrow_q == WR_LAST);
    end

    // Next-state computation for the sequencer, tag pipe and outputs
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        f4_re_d      = f4_re_q;
        f4_raddr_d   = f4_raddr_q;
        sub_d        = sub_q;
        wcol_d       = wcol_q;
        wrow_d       = wrow_q;
        win_d        = win_q;
        clr_pipe_d   = clr_pipe_q;
        we_pipe_d    = we_pipe_q;
        waddr_pipe_d = waddr_pipe_q;
        f5_waddr_d   = f5_waddr_q;
`ifdef POOL2_PERF_EN
        cycles_d     = cycles_q;
        if (busy_q && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
`endif

        // Tag of the read on the port enters the delay line each cycle
        clr_pipe_d[0]   = f4_re_q && (sub_q == 2'd0);
        we_pipe_d[0]    = f4_re_q && win_end;
        waddr_pipe_d[0] = win_q;
        for (int i = 1; i < RD_LAT; i++) begin
            clr_pipe_d[i]   = clr_pipe_q[i-1];
            we_pipe_d[i]    = we_pipe_q[i-1];
            waddr_pipe_d[i] = waddr_pipe_q[i-1];
        end

        // f5 stage: address only moves when a write is issued, so it holds
        f5_we_d = we_pipe_q[RD_LAT-1];
        if (we_pipe_q[RD_LAT-1]) begin
            f5_waddr_d = waddr_pipe_q[RD_LAT-1];
        end
        done_d = we_pipe_q[RD_LAT-1] && (waddr_pipe_q[RD_LAT-1] == WIN_LAST);

        case (state_q)
            ST_IDLE: begin
                if (pool2_start) begin
                    state_d    = ST_RUN;
                    busy_d     = 1'b1;
                    f4_re_d    = 1'b1;
                    f4_raddr_d = '0;
`ifdef POOL2_PERF_EN
                    cycles_d   = 16'd0;
`endif
                end
            end

            ST_RUN: begin
                sub_d = sub_q + 2'd1;
                if (win_end) begin
                    if (wcol_q == WC_LAST) begin
                        wcol_d = '0;
                        wrow_d = (wrow_q == WR_LAST) ? '0 : wrow_q + WR_W'(1);
                    end else begin
                        wcol_d = wcol_q + WC_W'(1);
                    end
                    win_d = (win_q == WIN_LAST) ? '0 : win_q + F5_AW'(1);
                end
                if (last_read) begin
                    state_d = ST_FLUSH;
                    f4_re_d = 1'b0;
                end else begin
                    f4_raddr_d = pix_addr(wrow_d, wcol_d, sub_d);
                end
            end

            ST_FLUSH: begin
                // done_q marks the final write; busy drops right after it
                if (done_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                f4_re_d = 1'b0;
            end
        endcase
    end

    // Register all sequencer state; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            f4_re_q      <= 1'b0;
            f4_raddr_q   <= '0;
            sub_q        <= '0;
            wcol_q       <= '0;
            wrow_q       <= '0;
            win_q        <= '0;
            clr_pipe_q   <= '0;
            we_pipe_q    <= '0;
            waddr_pipe_q <= '0;
            f5_we_q      <= 1'b0;
            f5_waddr_q   <= '0;
`ifdef POOL2_PERF_EN
            cycles_q     <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            f4_re_q      <= f4_re_d;
            f4_raddr_q   <= f4_raddr_d;
            sub_q        <= sub_d;
            wcol_q       <= wcol_d;
            wrow_q       <= wrow_d;
            win_q        <= win_d;
            clr_pipe_q   <= clr_pipe_d;
            we_pipe_q    <= we_pipe_d;
            waddr_pipe_q <= waddr_pipe_d;
            f5_we_q      <= f5_we_d;
            f5_waddr_q   <= f5_waddr_d;
`ifdef POOL2_PERF_EN
            cycles_q     <= cycles_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign pool2_busy = busy_q;
    assign pool2_done = done_q;
    assign f4_re      = f4_re_q;
    assign f4_raddr   = f4_raddr_q;
    assign pool2_clr  = clr_pipe_q[RD_LAT-1];
    assign f5_we      = f5_we_q;
    assign f5_waddr   = f5_waddr_q;
`ifdef POOL2_PERF_EN
    assign pool2_cycles = cycles_q;
`endif

endmodule
`default_nettype wire
